// File: rtl/scan_chain_reg_pkg.sv
// scan_chain_reg_pkg: shared sequencer state encoding and shift-direction constants
package scan_chain_reg_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } seq_state_t;
  localparam int DIR_TI_TO_MSB = 0;
  localparam int DIR_TI_TO_LSB = 1;
endpackage

// File: rtl/scan_seq_fsm.sv
// scan_seq_fsm: fixed-length automatic shift sequencer with busy/done handshake
module scan_seq_fsm
  import scan_chain_reg_pkg::*;
#(
  parameter int SHIFT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic shift_en,
  output logic starting,
  output logic busy,
  output logic done
);
  localparam int CW = $clog2(SHIFT_LEN + 1);
  seq_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  // state and remaining-shift counter registers
  always_ff @(posedge clk) begin
    state <= rst ? S_IDLE : state_nx;
    cnt   <= rst ? '0 : cnt_nx;
  end
  // transitions: the start cycle only arms the counter, the last shift runs at cnt == 0
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: if (start) begin
        state_nx = S_SHIFT;
        cnt_nx   = CW'(SHIFT_LEN - 1);
      end
      S_SHIFT: begin
        state_nx = (cnt == '0) ? S_DONE : S_SHIFT;
        cnt_nx   = (cnt == '0) ? cnt : cnt - 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end
  // decoded outputs to the datapath and handshake
  always_comb begin
    busy     = state == S_SHIFT;
    done     = state == S_DONE;
    shift_en = busy;
    starting = (state == S_IDLE) && start;
  end
endmodule

// File: rtl/scan_chain_reg.sv
// scan_chain_reg: WIDTH-bit scan chain register with auto shift sequencer; SCAN_SHADOW_EN adds a shadow output register
module scan_chain_reg
  import scan_chain_reg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SHIFT_LEN = WIDTH,
  parameter int SHIFT_DIR = DIR_TI_TO_MSB
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  input  logic             TE,
  input  logic             TI,
  input  logic             START,
  input  logic             UPDATE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             TO,
  output logic [WIDTH-1:0] SQ,
  output logic             BUSY,
  output logic             DONE
);
  logic [WIDTH-1:0] chain, shifted;
  logic shift_en, starting;
  scan_seq_fsm #(.SHIFT_LEN(SHIFT_LEN)) u_seq (
    .clk(CLK),
    .rst(RST),
    .start(START),
    .shift_en(shift_en),
    .starting(starting),
    .busy(BUSY),
    .done(DONE)
  );
  if (WIDTH == 1) begin : g_one
    assign shifted = TI;
  end else if (SHIFT_DIR == DIR_TI_TO_MSB) begin : g_up
    assign shifted = {chain[WIDTH-2:0], TI};
  end else begin : g_down
    assign shifted = {TI, chain[WIDTH-1:1]};
  end
  // auto shift beats manual shift beats capture; the start cycle freezes the chain
  always_ff @(posedge CLK) begin
    chain <= RST ? '0 : shift_en ? shifted : starting ? chain : TE ? shifted : LOAD ? D : chain;
  end
  assign Q  = chain;
  assign QN = ~chain;
  assign TO = (SHIFT_DIR == DIR_TI_TO_MSB) ? chain[WIDTH-1] : chain[0];
`ifdef SCAN_SHADOW_EN
  logic [WIDTH-1:0] shadow;
  // shadow copies the chain only when no sequence is shifting
  always_ff @(posedge CLK) begin
    shadow <= RST ? '0 : (UPDATE && !BUSY) ? chain : shadow;
  end
  assign SQ = shadow;
`else
  logic unused_update;
  assign unused_update = UPDATE;
  assign SQ = chain;
`endif
endmodule

// File: tb/tb_scan_chain_reg.sv
// tb_scan_chain_reg: directed self-checking bench for scan_chain_reg (WIDTH=8, SHIFT_LEN=8, SHIFT_DIR=0)
module tb_scan_chain_reg;
  logic CLK = 0, RST = 1, LOAD = 0, TE = 0, TI = 0, START = 0, UPDATE = 0;
  logic [7:0] D = '0, Q, QN, SQ;
  logic TO, BUSY, DONE;
  int total = 0, bad = 0;

  scan_chain_reg #(.WIDTH(8), .SHIFT_LEN(8), .SHIFT_DIR(0)) dut (
    .CLK(CLK), .RST(RST), .D(D), .LOAD(LOAD), .TE(TE), .TI(TI), .START(START),
    .UPDATE(UPDATE), .Q(Q), .QN(QN), .TO(TO), .SQ(SQ), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_value(input logic [7:0] v);
    LOAD = 1; D = v;
    tick();
    LOAD = 0;
    total++;
    if (Q !== v) begin bad++; $display("FAIL load: Q=%h want %h", Q, v); end
  endtask

  task automatic test_reset();
    RST = 1; LOAD = 1; D = 8'hA5;
    tick(); tick();
    total++; if (Q !== 8'h00) begin bad++; $display("FAIL reset_q: Q=%h want 00", Q); end
    total++; if (QN !== 8'hFF) begin bad++; $display("FAIL reset_qn: QN=%h want ff", QN); end
    total++; if (TO !== 1'b0) begin bad++; $display("FAIL reset_to: TO=%b want 0", TO); end
    total++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin bad++; $display("FAIL reset_hs: BUSY=%b DONE=%b want 0 0", BUSY, DONE); end
    total++; if (SQ !== 8'h00) begin bad++; $display("FAIL reset_sq: SQ=%h want 00", SQ); end
    RST = 0; LOAD = 0;
  endtask

  task automatic test_capture();
    LOAD = 1; D = 8'h3C;
    tick();
    total++; if (Q !== 8'h3C) begin bad++; $display("FAIL capture_q: Q=%h want 3c", Q); end
    total++; if (QN !== 8'hC3) begin bad++; $display("FAIL capture_qn: QN=%h want c3", QN); end
    TE = 1; TI = 1; D = 8'h00;
    tick();
    total++; if (Q !== 8'h79) begin bad++; $display("FAIL shift_over_load: Q=%h want 79", Q); end
    total++; if (TO !== 1'b0) begin bad++; $display("FAIL shift_over_load_to: TO=%b want 0", TO); end
    TE = 0; LOAD = 0; TI = 0;
  endtask

  task automatic test_manual_shift();
    logic [7:0] exp_to;
    exp_to = 8'b1000_0001;
    load_value(8'h81);
    TE = 1; TI = 0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (TO !== exp_to[i]) begin bad++; $display("FAIL manual_to[%0d]: TO=%b want %b", i, TO, exp_to[i]); end
      tick();
    end
    TE = 0;
    total++; if (Q !== 8'h00) begin bad++; $display("FAIL manual_final: Q=%h want 00", Q); end
  endtask

  task automatic test_auto_shift();
    load_value(8'hF0);
    TI = 1; START = 1;
    tick();
    START = 0;
    total++; if (Q !== 8'hF0 || BUSY !== 1'b1) begin bad++; $display("FAIL auto_start: Q=%h BUSY=%b want f0 1", Q, BUSY); end
    LOAD = 1; D = 8'h00; TE = 1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (BUSY !== 1'b1 || DONE !== 1'b0) begin bad++; $display("FAIL auto_busy[%0d]: BUSY=%b DONE=%b want 1 0", i, BUSY, DONE); end
      START = (i == 3);
      tick();
    end
    START = 0; TE = 0;
    total++; if (BUSY !== 1'b0 || DONE !== 1'b1) begin bad++; $display("FAIL auto_done: BUSY=%b DONE=%b want 0 1", BUSY, DONE); end
    total++; if (Q !== 8'hFF) begin bad++; $display("FAIL auto_final: Q=%h want ff", Q); end
    D = 8'h42;
    tick();
    LOAD = 0;
    total++; if (Q !== 8'h42) begin bad++; $display("FAIL done_cycle_load: Q=%h want 42", Q); end
    total++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("FAIL done_pulse: BUSY=%b DONE=%b want 0 0", BUSY, DONE); end
    tick();
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL no_queue: BUSY=%b want 0", BUSY); end
  endtask

  task automatic test_start_te();
    START = 1; TE = 1; TI = 1;
    tick();
    START = 0; TE = 0; TI = 0;
    total++; if (Q !== 8'h42 || BUSY !== 1'b1) begin bad++; $display("FAIL start_te: Q=%h BUSY=%b want 42 1", Q, BUSY); end
    for (int i = 0; i < 8; i++) tick();
    total++; if (DONE !== 1'b1 || Q !== 8'h00) begin bad++; $display("FAIL start_te_done: DONE=%b Q=%h want 1 00", DONE, Q); end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    load_value(8'hFF);
    START = 1;
    tick();
    START = 0;
    tick(); tick(); tick();
    total++; if (Q !== 8'hF8) begin bad++; $display("FAIL mid_progress: Q=%h want f8", Q); end
    RST = 1;
    tick();
    RST = 0;
    total++; if (BUSY !== 1'b0 || Q !== 8'h00) begin bad++; $display("FAIL mid_reset: BUSY=%b Q=%h want 0 00", BUSY, Q); end
    for (int i = 0; i < 12; i++) begin
      if (DONE === 1'b1) seen++;
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_no_done: DONE seen %0d times want 0", seen); end
  endtask

  task automatic test_shadow();
    load_value(8'h5A);
`ifdef SCAN_SHADOW_EN
    UPDATE = 1;
    tick();
    total++; if (SQ !== 8'h5A) begin bad++; $display("FAIL shadow_update: SQ=%h want 5a", SQ); end
    TI = 1; START = 1;
    tick();
    START = 0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (SQ !== 8'h5A) begin bad++; $display("FAIL shadow_hold[%0d]: SQ=%h want 5a", i, SQ); end
      tick();
    end
    total++; if (DONE !== 1'b1 || SQ !== 8'h5A) begin bad++; $display("FAIL shadow_done: DONE=%b SQ=%h want 1 5a", DONE, SQ); end
    tick();
    UPDATE = 0; TI = 0;
    total++; if (SQ !== 8'hFF) begin bad++; $display("FAIL shadow_after: SQ=%h want ff", SQ); end
`else
    total++; if (SQ !== 8'h5A) begin bad++; $display("FAIL sq_follow: SQ=%h want 5a", SQ); end
    UPDATE = 1; TE = 1; TI = 1;
    tick();
    UPDATE = 0; TE = 0; TI = 0;
    total++; if (SQ !== 8'hB5) begin bad++; $display("FAIL sq_follow_shift: SQ=%h want b5", SQ); end
`endif
  endtask

  initial begin
    test_reset();
    test_capture();
    test_manual_shift();
    test_auto_shift();
    test_start_te();
    test_reset_mid();
    test_shadow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scan_chain_reg.md
Name: scan_chain_reg

Overview:
- Parametrised successor to the single-bit scan flip-flop: a WIDTH-bit register whose bits form one serial scan chain.
- Supports functional parallel capture, manual scan shift under TE, and an automatic fixed-length shift sequencer with busy/done handshake.
- Sits wherever a multi-bit DELILAH-CPU state register must be observable and controllable from the test/diagnostic path.

Parameters:
- WIDTH, 8, number of register bits in the chain (1..64).
- SHIFT_LEN, WIDTH, shift cycles performed per automatic scan sequence (1..255).
- SHIFT_DIR, 0, 0 = TI enters bit 0 and TO is bit WIDTH-1; 1 = TI enters bit WIDTH-1 and TO is bit 0.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- D  in  WIDTH  functional parallel data.
- LOAD  in  1  functional capture enable.
- TE  in  1  manual scan-shift enable.
- TI  in  1  serial scan input.
- START  in  1  single-cycle request to start an automatic shift sequence.
- UPDATE  in  1  shadow update strobe (used only with SCAN_SHADOW_EN).
- Q  out  WIDTH  chain register contents.
- QN  out  WIDTH  bitwise inverse of Q.
- TO  out  1  serial scan output (end-of-chain bit, taken directly from the register).
- SQ  out  WIDTH  shadow/parallel output.
- BUSY  out  1  high while an automatic sequence is shifting.
- DONE  out  1  one-cycle pulse after the last automatic shift.

Behaviour:
- Single clock CLK; reset RST is synchronous and active-high.
- Reset values: Q = 0, QN = all ones, TO = 0, SQ = 0, BUSY = 0, DONE = 0, FSM = IDLE, counter = 0.
- Per-cycle priority: RST > automatic shift (FSM in SHIFT) > TE manual shift > LOAD capture > hold.
- Shift (SHIFT_DIR = 0): chain[0] <= TI; chain[i] <= chain[i-1].
- Shift (SHIFT_DIR = 1): the mirror image.
- TO reflects the new end-of-chain bit in the cycle after the edge.
- Capture: chain <= D when LOAD = 1 and no shift is active. Capture latency is 1 cycle.
- QN is always ~Q (combinational from the register).
- FSM states and transitions:
  - IDLE: START = 1 -> SHIFT, counter <= SHIFT_LEN-1. No shift occurs in the START cycle.
  - SHIFT: BUSY = 1; one shift per cycle. At counter = 0 -> DONE, else counter decrements. Exactly SHIFT_LEN shifts are performed.
  - DONE: DONE = 1 for this single cycle, BUSY = 0; -> IDLE. TE/LOAD are honoured in this cycle.
- Counter width is $clog2(SHIFT_LEN+1). No wrap: the counter stops at 0.
- Boundary conditions:
  - START while in SHIFT or DONE: ignored, and no queuing.
  - START and TE together in IDLE: the FSM starts; that cycle neither shifts nor captures.
  - TE or LOAD during SHIFT: ignored.
  - RST mid-sequence: immediate return to IDLE, chain cleared, DONE not asserted.
  - WIDTH = 1: the block behaves as a single scan flip-flop with an added sequencer.

Optional Feature:
- Macro SCAN_SHADOW_EN.
- Defined: a WIDTH-bit shadow register is added. SQ <= Q when UPDATE = 1 and BUSY = 0; UPDATE while BUSY is ignored. SQ is held otherwise and reset to 0. Functional logic reading SQ therefore never sees chain bits mid-shift.
- Undefined: no shadow register; SQ = Q combinationally; UPDATE is unused.

Decomposition:
- Shared package: the FSM state typedef (IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2) and the SHIFT_DIR encoding constants.
- One natural sub-module: scan_seq_fsm, containing the FSM, counter, BUSY and DONE, with output shift_en to the datapath.
- The chain datapath and the shadow register stay in scan_chain_reg.

Test Plan:
- Reset: RST = 1 for 2 cycles with LOAD = 1, D = 8'hA5 -> Q = 8'h00, QN = 8'hFF, TO = 0, BUSY = 0, DONE = 0.
- Capture: LOAD = 1, D = 8'h3C -> Q = 8'h3C, QN = 8'hC3 next cycle. Then TE = 1 and LOAD = 1 with TI = 1 -> shift wins, Q = 8'h79.
- Manual shift, SHIFT_DIR = 0, Q = 8'h81: TE = 1, TI = 0 for 8 cycles -> TO sequence 1,0,0,0,0,0,0,1; final Q = 8'h00.
- Auto shift, SHIFT_LEN = 8, Q = 8'hF0, TI = 1: pulse START -> BUSY high for exactly 8 cycles, DONE pulses 1 cycle, final Q = 8'hFF. A second START during BUSY has no effect.
- Reset mid-sequence: START, then RST in the 4th SHIFT cycle -> next cycle BUSY = 0, Q = 0, DONE never asserted.
- SCAN_SHADOW_EN defined: Q = 8'h5A, UPDATE -> SQ = 8'h5A. Auto shift with UPDATE held high during BUSY -> SQ stays 8'h5A until the first UPDATE after DONE.
